// File: rtl/gb_cpu_interrupt_dispatch.sv
// Purpose : sequences the 5-M-cycle Game Boy interrupt dispatch (undo prefetch, SP-1, push PCh, push PCl, PC <- vector).
// Latency : starts one cycle after an enabled interrupt is seen at an instruction boundary; busy for exactly 5 cycles.
// Backpressure: none accepted; busy stalls the decoder while the sequence owns the IDU/vector controls and bus writes.
//
// Ports:
//   clk, reset (async, active-low)
//   ie, if_flags, ime, instr_boundary, halted : interrupt state and decoder context
//   pc, sp                                    : live register-file values (sp already decremented between pushes)
//   busy, pc_dec, sp_dec                      : decoder stall and IDU requests
//   mem_wr, mem_addr, mem_wdata               : push write port (address/data zero when not writing)
//   write_interrupt_vector, interrupt_vector  : PC <- {00, vector} in M5; vector register is visible at all times
//   if_clear, ime_clear, halt_wake            : IF acknowledge, IME clear, HALT exit
module gb_cpu_interrupt_dispatch #(
    parameter logic [7:0] VECTOR_BASE   = 8'h40,
    parameter logic [7:0] VECTOR_STRIDE = 8'h08,
    parameter bit         LATE_CANCEL   = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  ie,
    input  logic [4:0]  if_flags,
    input  logic        ime,
    input  logic        instr_boundary,
    input  logic        halted,
    input  logic [15:0] pc,
    input  logic [15:0] sp,
    output logic        busy,
    output logic        pc_dec,
    output logic        sp_dec,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        write_interrupt_vector,
    output logic [7:0]  interrupt_vector,
    output logic [4:0]  if_clear,
    output logic        ime_clear,
    output logic        halt_wake
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_M1   = 3'd1,
        S_M2   = 3'd2,
        S_M3   = 3'd3,
        S_M4   = 3'd4,
        S_M5   = 3'd5
    } state_t;

    state_t      state, state_nxt;
    logic [4:0]  pending;
    logic        any_pending;
    logic [7:0]  sel_vec;
    logic [4:0]  sel_mask;
    logic [7:0]  vec_q;
    logic [4:0]  mask_q;

    assign pending     = ie & if_flags;
    assign any_pending = |pending;

    // HALT exit does not depend on IME.
    assign halt_wake = halted & any_pending;

    // Fixed priority: scan from the top so the lowest set bit is assigned last and wins.
    // Nothing pending leaves vector 00 and an empty mask, which is the cancel outcome.
    always_comb begin
        sel_vec  = 8'h00;
        sel_mask = 5'b00000;
        for (int i = 4; i >= 0; i--) begin
            if (pending[i]) begin
                sel_vec     = VECTOR_BASE + VECTOR_STRIDE * 8'(i);
                sel_mask    = 5'b00000;
                sel_mask[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= S_IDLE;
            vec_q  <= 8'h00;
            mask_q <= 5'b00000;
        end else begin
            state <= state_nxt;
            // Early selection captures vector and mask together at M1; late selection
            // samples at M4 so the PC_hi push can still cancel the interrupt.
            if (!LATE_CANCEL && state == S_M1) begin
                vec_q  <= sel_vec;
                mask_q <= sel_mask;
            end
            if (LATE_CANCEL && state == S_M4) begin
                vec_q <= sel_vec;
            end
        end
    end

    always_comb begin
        state_nxt              = state;
        busy                   = 1'b0;
        pc_dec                 = 1'b0;
        sp_dec                 = 1'b0;
        mem_wr                 = 1'b0;
        mem_addr               = 16'h0000;
        mem_wdata              = 8'h00;
        write_interrupt_vector = 1'b0;
        if_clear               = 5'b00000;
        ime_clear              = 1'b0;
        case (state)
            S_IDLE: begin
                if (ime && any_pending && instr_boundary && !halted) begin
                    state_nxt = S_M1;
                end
            end
            S_M1: begin
                busy      = 1'b1;
                pc_dec    = 1'b1;
                ime_clear = 1'b1;
                state_nxt = S_M2;
            end
            S_M2: begin
                busy      = 1'b1;
                sp_dec    = 1'b1;
                state_nxt = S_M3;
            end
            S_M3: begin
                busy      = 1'b1;
                mem_wr    = 1'b1;
                mem_addr  = sp;
                mem_wdata = pc[15:8];
                sp_dec    = 1'b1;
                state_nxt = S_M4;
            end
            S_M4: begin
                busy      = 1'b1;
                mem_wr    = 1'b1;
                mem_addr  = sp;
                mem_wdata = pc[7:0];
                if_clear  = LATE_CANCEL ? sel_mask : mask_q;
                state_nxt = S_M5;
            end
            S_M5: begin
                busy                   = 1'b1;
                write_interrupt_vector = 1'b1;
                // Always pass through IDLE so back-to-back dispatches have a gap.
                state_nxt              = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign interrupt_vector = vec_q;

endmodule
